// File: rtl/cpu_state_sequencer.sv
// Multicycle FETCH/DECODE/EXEC1/EXEC2 sequencer with Avalon stall hold and halt detection.
// Optional stall timeout abort is enabled by defining STATE_SEQ_TIMEOUT_EN.
module cpu_state_sequencer #(
    parameter int unsigned STALL_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [5:0]  opcode,
    input  logic [31:0] pc_next,
    output logic [3:0]  state,
    output logic        active,
    output logic        mem_done,
    output logic [31:0] cycle_count,
    output logic        error
);

    typedef enum logic [3:0] {
        StHalt   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StExec1  = 4'd3,
        StExec2  = 4'd4
    } state_e;

    state_e      state_q, state_d;
    logic        active_q, active_d;
    logic [31:0] cycle_count_q, cycle_count_d;

    logic mem_req;
    logic stall;
    logic mem_phase;
    logic opcode_legal;
    logic timeout;

    assign mem_req      = memread | memwrite;
    assign stall        = mem_req & waitrequest;
    assign mem_phase    = state_q inside {StFetch, StExec1, StExec2};
    assign mem_done     = mem_phase & mem_req & ~waitrequest;
    assign opcode_legal = opcode inside {6'b000000, 6'b100011, 6'b101011,
                                         6'b000100, 6'b000010, 6'b000011};

`ifdef STATE_SEQ_TIMEOUT_EN
    localparam logic [31:0] StallMax = 32'(STALL_LIMIT);

    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        error_q, error_d;

    // Only stalls in a memory-access state can hold the sequencer, so only those count.
    assign timeout = mem_phase & stall & (stall_cnt_q == StallMax - 32'd1);

    always_comb begin
        stall_cnt_d = '0;
        if (mem_phase && stall) begin
            stall_cnt_d = (stall_cnt_q == StallMax) ? stall_cnt_q : stall_cnt_q + 32'd1;
        end
        error_d = error_q | timeout;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            error_q     <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            error_q     <= error_d;
        end
    end

    assign error = error_q;
`else
    logic unused_stall_limit;

    assign unused_stall_limit = ^(32'(STALL_LIMIT));
    assign timeout            = 1'b0;
    assign error              = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StHalt:   state_d = StHalt;
            StFetch:  if (!stall) state_d = StDecode;
            StDecode: state_d = opcode_legal ? StExec1 : StHalt;
            StExec1:  if (!stall) state_d = StExec2;
            StExec2: begin
                if (!stall) state_d = (pc_next == '0) ? StHalt : StFetch;
            end
            default:  state_d = StHalt;
        endcase
        if (timeout) begin
            state_d = StHalt;
        end

        active_d = (state_d != StHalt);

        cycle_count_d = cycle_count_q;
        if (state_q != StHalt && cycle_count_q != '1) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StFetch;
            active_q      <= 1'b1;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign state       = state_q;
    assign active      = active_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_state_sequencer.sv
// Table-driven bench for cpu_state_sequencer: each vector gives inputs for one cycle, the
// expected mem_done before the edge and the expected registered outputs after it.
module tb_cpu_state_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        waitrequest;
    logic        memread;
    logic        memwrite;
    logic [5:0]  opcode;
    logic [31:0] pc_next;
    logic [3:0]  state;
    logic        active;
    logic        mem_done;
    logic [31:0] cycle_count;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cpu_state_sequencer #(
        .STALL_LIMIT(4)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .waitrequest(waitrequest),
        .memread    (memread),
        .memwrite   (memwrite),
        .opcode     (opcode),
        .pc_next    (pc_next),
        .state      (state),
        .active     (active),
        .mem_done   (mem_done),
        .cycle_count(cycle_count),
        .error      (error)
    );

    typedef struct {
        logic        rst;
        logic        wr;
        logic        mr;
        logic        mw;
        logic [5:0]  op;
        logic [31:0] pc;
        logic        exp_done;
        logic [3:0]  exp_state;
        logic        exp_active;
        logic [31:0] exp_cnt;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(input logic rst, input logic wr, input logic mr, input logic mw,
                                input logic [5:0] op, input logic [31:0] pc, input logic done,
                                input logic [3:0] st, input logic [31:0] cnt, input logic err);
        vec_t v;
        v.rst        = rst;
        v.wr         = wr;
        v.mr         = mr;
        v.mw         = mw;
        v.op         = op;
        v.pc         = pc;
        v.exp_done   = done;
        v.exp_state  = st;
        v.exp_active = (st != 4'd0);
        v.exp_cnt    = cnt;
        v.exp_err    = err;
        return v;
    endfunction

    task automatic add(input logic rst, input logic wr, input logic mr, input logic mw,
                       input logic [5:0] op, input logic [31:0] pc, input logic done,
                       input logic [3:0] st, input logic [31:0] cnt);
        vecs.push_back(mk(rst, wr, mr, mw, op, pc, done, st, cnt, 1'b0));
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        reset       = v.rst;
        waitrequest = v.wr;
        memread     = v.mr;
        memwrite    = v.mw;
        opcode      = v.op;
        pc_next     = v.pc;
        #1;
        check("mem_done", {31'b0, mem_done}, {31'b0, v.exp_done});
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("state", {28'b0, state}, {28'b0, e.exp_state});
        check("active", {31'b0, active}, {31'b0, e.exp_active});
        check("cycle_count", cycle_count, e.exp_cnt);
        check("error", {31'b0, error}, {31'b0, e.exp_err});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  ops[6];
        logic [31:0] c;
        ops[0] = 6'b000000;
        ops[1] = 6'b100011;
        ops[2] = 6'b101011;
        ops[3] = 6'b000100;
        ops[4] = 6'b000010;
        ops[5] = 6'b000011;

        // Reset, then a plain R-type instruction; waitrequest without a request is ignored.
        add(1, 0, 0, 0, 6'h00, 32'h10, 0, 1, 0);
        add(0, 0, 1, 0, 6'h00, 32'h10, 1, 2, 1);
        add(0, 1, 0, 0, 6'h00, 32'h10, 0, 3, 2);
        add(0, 0, 1, 0, 6'h00, 32'h10, 1, 4, 3);
        add(0, 1, 0, 0, 6'h00, 32'h10, 0, 1, 4);
        // FETCH stalled three cycles, then released.
        add(0, 1, 1, 0, 6'h00, 32'h10, 0, 1, 5);
        add(0, 1, 1, 0, 6'h00, 32'h10, 0, 1, 6);
        add(0, 1, 1, 0, 6'h00, 32'h10, 0, 1, 7);
        add(0, 0, 1, 0, 6'h00, 32'h10, 1, 2, 8);
        // lw with EXEC1 stalled twice, then halt on pc_next == 0, then idle in HALT.
        add(0, 0, 0, 0, 6'h23, 32'h0, 0, 3, 9);
        add(0, 1, 1, 0, 6'h23, 32'h0, 0, 3, 10);
        add(0, 1, 1, 0, 6'h23, 32'h0, 0, 3, 11);
        add(0, 0, 1, 0, 6'h23, 32'h0, 1, 4, 12);
        add(0, 0, 0, 0, 6'h23, 32'h0, 0, 0, 13);
        for (int i = 0; i < 10; i++) add(0, 0, 1, 0, 6'h23, 32'h0, 0, 0, 13);
        // Illegal opcode in DECODE.
        add(1, 0, 0, 0, 6'h00, 32'h10, 0, 1, 0);
        add(0, 0, 1, 0, 6'h00, 32'h10, 1, 2, 1);
        add(0, 0, 1, 0, 6'h3f, 32'h10, 0, 0, 2);
        add(1, 0, 0, 0, 6'h00, 32'h10, 0, 1, 0);
        // Every legal opcode runs a full instruction; a near-miss opcode halts.
        c = 0;
        for (int k = 0; k < 6; k++) begin
            add(0, 0, 1, 0, ops[k], 32'h4, 1, 2, c + 1);
            add(0, 0, 0, 0, ops[k], 32'h4, 0, 3, c + 2);
            add(0, 0, 0, 1, ops[k], 32'h4, 1, 4, c + 3);
            add(0, 0, 0, 0, ops[k], 32'h4, 0, 1, c + 4);
            c = c + 4;
        end
        add(0, 0, 1, 0, 6'h01, 32'h4, 1, 2, c + 1);
        add(0, 0, 0, 0, 6'h01, 32'h4, 0, 0, c + 2);
        // Reset asserted while EXEC2 is stalled on a write.
        add(1, 0, 0, 0, 6'h2b, 32'h8, 0, 1, 0);
        add(0, 0, 1, 0, 6'h2b, 32'h8, 1, 2, 1);
        add(0, 0, 0, 0, 6'h2b, 32'h8, 0, 3, 2);
        add(0, 0, 0, 1, 6'h2b, 32'h8, 1, 4, 3);
        add(0, 1, 0, 1, 6'h2b, 32'h8, 0, 4, 4);
        add(1, 1, 0, 1, 6'h2b, 32'h8, 0, 1, 0);

        foreach (vecs[i]) step(vecs[i]);

        // Long FETCH stall: aborts after four stalled cycles only with the timeout enabled.
        for (int i = 0; i < 100; i++) begin
`ifdef STATE_SEQ_TIMEOUT_EN
            if (i >= 3) step(mk(0, 1, 1, 0, 6'h00, 32'h10, 0, 0, 4, 1));
            else        step(mk(0, 1, 1, 0, 6'h00, 32'h10, 0, 1, i + 1, 0));
`else
            step(mk(0, 1, 1, 0, 6'h00, 32'h10, 0, 1, i + 1, 0));
`endif
        end
        step(mk(1, 0, 0, 0, 6'h00, 32'h10, 0, 1, 0, 0));
        step(mk(0, 0, 1, 0, 6'h00, 32'h10, 1, 2, 1, 0));

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
